// File: rtl/fetch_sequencer.sv
// Instruction-fetch/control sequencer for the single-cycle datapath: walks the
// instruction address, gates RegWrite/MemWrite, supports run, pause, single-step and loop.
module fetch_sequencer #(
    parameter int                   ADDR_W        = 3,
    parameter int                   PROG_LEN      = 8,
    parameter logic [2**ADDR_W-1:0] REGWRITE_MASK = 8'hFF,
    parameter logic [2**ADDR_W-1:0] MEMWRITE_MASK = 8'h00,
    parameter bit                   LOOP          = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] instr_addr,
    output logic              reg_write,
    output logic              mem_write,
    output logic              running,
    output logic              done,
    output logic [7:0]        exec_count
);

    typedef enum logic [2:0] {IDLE, RUN, PAUSE, STEP, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);

    state_t            state;
    logic              step_q;
    logic              exec;
    logic              step_rise;
    logic              at_last;
    logic              stop;
    logic [ADDR_W-1:0] nxt_addr;

    assign exec      = (state == RUN) || (state == STEP);
    assign step_rise = step & ~step_q;
    assign at_last   = (instr_addr == LAST);
    // Last instruction without looping: address parks on PROG_LEN-1 and we finish.
    assign stop      = at_last & ~LOOP;
    assign nxt_addr  = at_last ? '0 : instr_addr + ADDR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            instr_addr <= '0;
            exec_count <= '0;
            step_q     <= 1'b0;
        end else begin
            // Sampled in every state so an edge seen during RUN is not replayed in PAUSE.
            step_q <= step;
            if (exec && exec_count != 8'hFF)
                exec_count <= exec_count + 8'd1;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        instr_addr <= '0;
                        exec_count <= '0;
                        state      <= step_mode ? PAUSE : RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= DONE;
                    end else begin
                        instr_addr <= nxt_addr;
                        if (halt_req)
                            state <= PAUSE;
                    end
                end
                PAUSE: begin
                    if (start)
                        state <= RUN;
                    else if (step_rise)
                        state <= STEP;
                end
                STEP: begin
                    if (stop) begin
                        state <= DONE;
                    end else begin
                        instr_addr <= nxt_addr;
                        state      <= PAUSE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign reg_write = exec & REGWRITE_MASK[instr_addr];
    assign mem_write = exec & MEMWRITE_MASK[instr_addr];
    assign running   = exec;
    assign done      = (state == DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: three parameterisations driven in parallel, checked every
// cycle against a per-instance behavioural model plus directed literal expectations.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic rst, start, step_mode, step, halt_req;

    logic [2:0] a0, a1, a2;
    logic       rw0, rw1, rw2, mw0, mw1, mw2, run0, run1, run2, dn0, dn1, dn2;
    logic [7:0] c0, c1, c2;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDR_W(3), .PROG_LEN(8), .REGWRITE_MASK(8'h0F), .MEMWRITE_MASK(8'h30), .LOOP(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step), .halt_req(halt_req),
        .instr_addr(a0), .reg_write(rw0), .mem_write(mw0), .running(run0), .done(dn0), .exec_count(c0));

    fetch_sequencer #(.ADDR_W(3), .PROG_LEN(8), .REGWRITE_MASK(8'hFF), .MEMWRITE_MASK(8'h00), .LOOP(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step), .halt_req(halt_req),
        .instr_addr(a1), .reg_write(rw1), .mem_write(mw1), .running(run1), .done(dn1), .exec_count(c1));

    fetch_sequencer #(.ADDR_W(3), .PROG_LEN(1), .REGWRITE_MASK(8'h01), .MEMWRITE_MASK(8'h01), .LOOP(1'b0)) u2 (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step), .halt_req(halt_req),
        .instr_addr(a2), .reg_write(rw2), .mem_write(mw2), .running(run2), .done(dn2), .exec_count(c2));

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_STEP = 3, S_DONE = 4;

    typedef struct {
        int st;
        int addr;
        int cnt;
        bit sq;
    } mdl_t;

    mdl_t m0, m1, m2;
    int   vectors = 0;
    int   miscompares = 0;
    bit   chk_en = 1'b0;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = S_IDLE; r.addr = 0; r.cnt = 0; r.sq = 1'b0;
        return r;
    endfunction

    // One clock of the sequencer rules, in plain arithmetic.
    function automatic mdl_t mstep(input mdl_t m, input int plen, input bit loop,
                                   input bit st_in, input bit sm, input bit stp, input bit hlt);
        mdl_t n;
        bit   rise;
        bit   last;
        n    = m;
        rise = stp && !m.sq;
        last = (m.addr == plen - 1);
        n.sq = stp;
        if (m.st == S_IDLE || m.st == S_DONE) begin
            if (st_in) begin
                n.addr = 0; n.cnt = 0;
                n.st   = sm ? S_PAUSE : S_RUN;
            end
        end else if (m.st == S_RUN || m.st == S_STEP) begin
            n.cnt = (m.cnt < 255) ? m.cnt + 1 : 255;
            if (last && !loop) begin
                n.st = S_DONE;
            end else begin
                n.addr = (m.addr + 1) % plen;
                n.st   = (m.st == S_STEP || hlt) ? S_PAUSE : S_RUN;
            end
        end else begin
            if (st_in)     n.st = S_RUN;
            else if (rise) n.st = S_STEP;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m0 <= mreset(); m1 <= mreset(); m2 <= mreset();
        end else begin
            m0 <= mstep(m0, 8, 1'b0, start, step_mode, step, halt_req);
            m1 <= mstep(m1, 8, 1'b1, start, step_mode, step, halt_req);
            m2 <= mstep(m2, 1, 1'b0, start, step_mode, step, halt_req);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input string tag, input mdl_t m, input logic [7:0] rm, input logic [7:0] mm,
                       input logic [2:0] addr, input logic rw, input logic mw, input logic run,
                       input logic dn, input logic [7:0] cnt);
        bit ex;
        ex = (m.st == S_RUN || m.st == S_STEP);
        check({tag, ".instr_addr"}, 32'(addr), 32'(m.addr));
        check({tag, ".reg_write"},  32'(rw),   32'(ex & rm[m.addr]));
        check({tag, ".mem_write"},  32'(mw),   32'(ex & mm[m.addr]));
        check({tag, ".running"},    32'(run),  32'(ex));
        check({tag, ".done"},       32'(dn),   32'(m.st == S_DONE));
        check({tag, ".exec_count"}, 32'(cnt),  32'(m.cnt));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("u0", m0, 8'h0F, 8'h30, a0, rw0, mw0, run0, dn0, c0);
            cmp("u1", m1, 8'hFF, 8'h00, a1, rw1, mw1, run1, dn1, c1);
            cmp("u2", m2, 8'h01, 8'h01, a2, rw2, mw2, run2, dn2, c2);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_start(input bit sm);
        start = 1'b1; step_mode = sm;
        tick(1);
        start = 1'b0; step_mode = 1'b0;
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; halt_req = 1'b0;
        tick(2);
        chk_en = 1'b1;
        check("rst.u0.instr_addr", 32'(a0), 0);
        check("rst.u0.reg_write", 32'(rw0), 0);
        check("rst.u1.running", 32'(run1), 0);
        check("rst.u1.exec_count", 32'(c1), 0);
        rst = 1'b1;
        tick(1);

        // Free run to DONE
        pulse_start(1'b0);
        tick(9);
        check("free.u0.done", 32'(dn0), 1);
        check("free.u0.instr_addr", 32'(a0), 7);
        check("free.u0.exec_count", 32'(c0), 8);
        check("free.model.cnt", 32'(m0.cnt), 8);
        check("free.u2.done", 32'(dn2), 1);
        check("free.u2.exec_count", 32'(c2), 1);

        // Halt at address 2, idle, then resume
        pulse_start(1'b0);
        for (int k = 0; k < 20 && a0 != 3'd2; k++) tick(1);
        check("halt.reach_addr2", 32'(a0), 2);
        halt_req = 1'b1;
        tick(1);
        halt_req = 1'b0;
        tick(5);
        check("halt.u0.instr_addr", 32'(a0), 3);
        check("halt.u0.running", 32'(run0), 0);
        check("halt.u0.reg_write", 32'(rw0), 0);
        check("halt.u0.exec_count", 32'(c0), 3);
        pulse_start(1'b0);
        tick(6);
        check("resume.u0.done", 32'(dn0), 1);
        check("resume.u0.exec_count", 32'(c0), 8);

        // Single step: three pulses then one long hold
        pulse_start(1'b1);
        check("step.u0.instr_addr0", 32'(a0), 0);
        repeat (3) begin
            step = 1'b1; tick(1);
            step = 1'b0; tick(2);
        end
        step = 1'b1; tick(10);
        step = 1'b0; tick(3);
        check("step.u0.instr_addr", 32'(a0), 4);
        check("step.u0.exec_count", 32'(c0), 4);
        check("step.u0.running", 32'(run0), 0);

        // Asynchronous reset while running at address 5
        pulse_start(1'b0);
        for (int k = 0; k < 20 && a0 != 3'd5; k++) tick(1);
        check("rstmid.reach_addr5", 32'(a0), 5);
        #1 rst = 1'b0;
        #1;
        check("rstmid.u0.instr_addr", 32'(a0), 0);
        check("rstmid.u0.reg_write", 32'(rw0), 0);
        check("rstmid.u0.running", 32'(run0), 0);
        check("rstmid.u1.reg_write", 32'(rw1), 0);
        tick(2);
        rst = 1'b1;
        tick(3);
        check("rstmid.idle.running", 32'(run0), 0);
        check("rstmid.idle.done", 32'(dn0), 0);

        // Looping instance saturates, never finishes
        pulse_start(1'b0);
        tick(300);
        check("loop.u1.exec_count", 32'(c1), 255);
        check("loop.u1.done", 32'(dn1), 0);
        check("loop.u1.running", 32'(run1), 1);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 2000; i++) begin
            start     = ($urandom_range(0, 15) == 0);
            step_mode = 1'($urandom_range(0, 1));
            step      = 1'($urandom_range(0, 1));
            halt_req  = ($urandom_range(0, 7) == 0);
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b0;
            end
            tick(1);
        end
        rst = 1'b1;
        tick(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
